// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller.
// Optional misaligned-access check: define DMEM_MISALIGN_CHK_EN.
package dmem_pkg;

   localparam int DMEM_CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } dmem_state_e;

   function automatic int dmem_log2(input int depth);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < depth) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH x 32 word RAM.
// Synchronous write, asynchronous read.
module dmem_array #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[addr] <= wdata;
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/data_mem_ctrl.sv
// Wait-state data-memory responder with PC stall for the RV32F core.
// Define DMEM_MISALIGN_CHK_EN to suppress and flag misaligned accesses.
module data_mem_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [31:0] a_data_mem,
   input  logic [31:0] w_data_mem,
   output logic [31:0] r_data_mem,
   output logic        stall,
   output logic        misalign
);

   localparam int AW = dmem_log2(DEPTH);
   localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
   localparam logic [DMEM_CNT_W-1:0] CNT_LOAD =
      DMEM_CNT_W'(WAIT_CYCLES - 1);
   localparam logic [DMEM_CNT_W-1:0] CNT_ONE = DMEM_CNT_W'(1);

   dmem_state_e           state_q, state_d;
   logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]           r_data_q, r_data_d;
   logic                  misalign_q, misalign_d;

   logic          req, rd_only, mis, ram_we, done_entry;
   logic [AW-1:0] idx;
   logic [31:0]   ram_rdata, load_val;
   logic          addr_unused;

   assign req     = mem_rd | mem_wr;
   assign rd_only = mem_rd & ~mem_wr;
   assign idx     = a_data_mem[AW+1:2];
   assign addr_unused = ^{a_data_mem[31:AW+2], a_data_mem[1:0]};

`ifdef DMEM_MISALIGN_CHK_EN
   assign mis = (a_data_mem[1:0] != 2'b00);
`else
   assign mis = 1'b0;
`endif

   dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
      .clk   (clk),
      .we    (ram_we),
      .addr  (idx),
      .wdata (w_data_mem),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         r_data_q   <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         r_data_q   <= r_data_d;
         misalign_q <= misalign_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req && !ZERO_WAIT) begin
               if (WAIT_CYCLES > 1) begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_LOAD;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_WAIT: begin
            if (!req) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_ONE) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Load data is captured on the edge entering DONE so it is valid there.
   always_comb begin
      done_entry = (state_d == ST_DONE) && (state_q != ST_DONE);
      load_val   = mis ? 32'h0 : ram_rdata;
      r_data_d   = r_data_q;
      misalign_d = 1'b0;
      if (ZERO_WAIT) begin
         if (rd_only) r_data_d = load_val;
      end else if (done_entry) begin
         misalign_d = mis;
         if (rd_only) r_data_d = load_val;
      end
   end

   always_comb begin
      ram_we = reset & mem_wr & ~mis;
      if (!ZERO_WAIT) ram_we = ram_we & (state_q == ST_DONE);
      stall = reset & req & (state_q != ST_DONE) & ~ZERO_WAIT;
      r_data_mem = (ZERO_WAIT && rd_only) ? load_val : r_data_q;
      misalign = ZERO_WAIT ? (reset & req & mis) : misalign_q;
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: wait-state and zero-wait instances
// checked against a word-array reference model.
module tb_data_mem_ctrl;

`ifdef DMEM_MISALIGN_CHK_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_rd, mem_wr;
   logic [31:0] a_data_mem, w_data_mem, r_data_mem;
   logic        stall, misalign;

   logic        z_rd, z_wr;
   logic [31:0] z_addr, z_wdata, z_rdata;
   logic        z_stall, z_mis;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] model_mem [1024];
   logic [31:0] last_load = 32'h0;

   always #5 clk = ~clk;

   data_mem_ctrl #(.DEPTH(1024), .WAIT_CYCLES(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_rd     (mem_rd),
      .mem_wr     (mem_wr),
      .a_data_mem (a_data_mem),
      .w_data_mem (w_data_mem),
      .r_data_mem (r_data_mem),
      .stall      (stall),
      .misalign   (misalign)
   );

   data_mem_ctrl #(.DEPTH(16), .WAIT_CYCLES(0)) dut0 (
      .clk        (clk),
      .reset      (reset),
      .mem_rd     (z_rd),
      .mem_wr     (z_wr),
      .a_data_mem (z_addr),
      .w_data_mem (z_wdata),
      .r_data_mem (z_rdata),
      .stall      (z_stall),
      .misalign   (z_mis)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One complete access, entered and left at a falling edge.
   task automatic access(input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data,
                         input string tag);
      int   stalls;
      int   idx;
      logic mis;
      idx = int'((addr >> 2) % 1024);
      mis = MIS_EN && (addr[1:0] != 2'b00);
      if (wr) begin
         if (!mis) model_mem[idx] = data;
      end else if (rd) begin
         last_load = mis ? 32'h0 : model_mem[idx];
      end
      mem_rd = rd;
      mem_wr = wr;
      a_data_mem = addr;
      w_data_mem = data;
      stalls = 0;
      #1;
      while (stall === 1'b1 && stalls < 20) begin
         stalls++;
         @(negedge clk);
         #1;
      end
      check({tag, " stalls"}, 32'(stalls), 32'd2);
      check({tag, " rdata"}, r_data_mem, last_load);
      check({tag, " misalign"}, {31'h0, misalign}, {31'h0, mis});
      @(negedge clk);
      mem_rd = 1'b0;
      mem_wr = 1'b0;
   endtask

   task automatic idle_check(input string tag);
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      #1;
      check({tag, " idle stall"}, {31'h0, stall}, 32'h0);
      check({tag, " idle misalign"}, {31'h0, misalign}, 32'h0);
      check({tag, " idle rdata"}, r_data_mem, last_load);
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0;
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      a_data_mem = '0;
      w_data_mem = '0;
      z_rd = 1'b0;
      z_wr = 1'b0;
      z_addr = '0;
      z_wdata = '0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("reset stall", {31'h0, stall}, 32'h0);
      check("reset rdata", r_data_mem, 32'h0);
      check("reset misalign", {31'h0, misalign}, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 32; i++)
         access(1'b0, 1'b1, 32'(i * 4), $urandom, "preinit");

      access(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, "st 0x40");
      access(1'b1, 1'b0, 32'h40, 32'h0, "ld 0x40");
      idle_check("after ld");

      access(1'b0, 1'b1, 32'h1000, 32'hA5A5A5A5, "st wrap");
      access(1'b1, 1'b0, 32'h0000, 32'h0, "ld wrap");

      // Reset during the wait of a store must drop the store.
      access(1'b0, 1'b1, 32'h20, 32'h0, "st 0x20 zero");
      mem_wr = 1'b1;
      a_data_mem = 32'h20;
      w_data_mem = 32'h1;
      #1;
      check("rst pre stall", {31'h0, stall}, 32'h1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst stall low", {31'h0, stall}, 32'h0);
      @(negedge clk);
      #1;
      check("rst after stall", {31'h0, stall}, 32'h0);
      check("rst after rdata", r_data_mem, 32'h0);
      last_load = 32'h0;
      mem_wr = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      access(1'b1, 1'b0, 32'h20, 32'h0, "ld 0x20 after rst");

      // Withdrawn store must leave the word untouched.
      mem_wr = 1'b1;
      a_data_mem = 32'h44;
      w_data_mem = 32'hCAFEF00D;
      #1;
      check("wd stall", {31'h0, stall}, 32'h1);
      @(negedge clk);
      mem_wr = 1'b0;
      #1;
      check("wd dropped stall", {31'h0, stall}, 32'h0);
      @(negedge clk);
      access(1'b1, 1'b0, 32'h44, 32'h0, "ld 0x44 after wd");

      access(1'b1, 1'b1, 32'h48, 32'h11112222, "rd+wr 0x48");
      access(1'b1, 1'b0, 32'h48, 32'h0, "ld 0x48");

      access(1'b0, 1'b1, 32'h42, 32'h55AA55AA, "st 0x42");
      idle_check("after st 0x42");
      access(1'b1, 1'b0, 32'h41, 32'h0, "ld 0x41");
      access(1'b1, 1'b0, 32'h40, 32'h0, "ld 0x40 again");

      for (int k = 0; k < 40; k++) begin
         logic        rd, wr;
         logic [31:0] addr;
         rd = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         addr = ($urandom & ~32'h0000_0FFC) |
                (32'($urandom_range(0, 31)) << 2);
         if (rd || wr)
            access(rd, wr, addr, $urandom, $sformatf("rnd%0d", k));
         else
            idle_check($sformatf("rnd%0d", k));
      end

      // Zero-wait instance.
      z_wr = 1'b1;
      z_addr = 32'h10;
      z_wdata = 32'h12345678;
      #1;
      check("zw st stall", {31'h0, z_stall}, 32'h0);
      @(negedge clk);
      z_wr = 1'b0;
      z_rd = 1'b1;
      #1;
      check("zw ld rdata", z_rdata, 32'h12345678);
      check("zw ld stall", {31'h0, z_stall}, 32'h0);
      check("zw ld misalign", {31'h0, z_mis}, 32'h0);
      @(negedge clk);
      z_wr = 1'b1;
      z_wdata = 32'hFFFF0000;
      #1;
      check("zw rd+wr rdata", z_rdata, 32'h12345678);
      check("zw rd+wr stall", {31'h0, z_stall}, 32'h0);
      @(negedge clk);
      z_wr = 1'b0;
      #1;
      check("zw ld2 rdata", z_rdata, 32'hFFFF0000);
      @(negedge clk);
      z_addr = 32'h12;
      #1;
      check("zw ld mis rdata", z_rdata, MIS_EN ? 32'h0 : 32'hFFFF0000);
      check("zw ld mis flag", {31'h0, z_mis}, {31'h0, MIS_EN});
      @(negedge clk);
      z_rd = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
